// File: rtl/bcd_pkg.sv
// Shared constants and helpers for the BCD scan counter.
// The segment patterns are active-high, {dp,g,f,e,d,c,b,a}.
// Output polarity is applied later, in the top module.
package bcd_pkg;

    localparam logic [7:0] SEG_0     = 8'h3F;
    localparam logic [7:0] SEG_1     = 8'h06;
    localparam logic [7:0] SEG_2     = 8'h5B;
    localparam logic [7:0] SEG_3     = 8'h4F;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'h6D;
    localparam logic [7:0] SEG_6     = 8'h7D;
    localparam logic [7:0] SEG_7     = 8'h07;
    localparam logic [7:0] SEG_8     = 8'h7F;
    localparam logic [7:0] SEG_9     = 8'h6F;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Decimal digit to segment pattern.
    // Any nibble that is not a decimal digit shows blank.
    function automatic logic [7:0] bcd_to_seg(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bcd_scan_counter_if.sv
// Bus between the BCD scan counter and whatever drives it.
// The bus carries the control inputs, the load value, the count and carry, and the display lines.
interface bcd_scan_counter_if #(
    parameter int DIGITS = 4
);
    logic                  en;
    logic                  up;
    logic                  Load;
    logic [4*DIGITS-1:0]   Din;
    logic [4*DIGITS-1:0]   count;
    logic                  carry;
    logic [7:0]            seg;
    logic [DIGITS-1:0]     an;

    modport master (
        output en, up, Load, Din,
        input  count, carry, seg, an
    );

    modport slave (
        input  en, up, Load, Din,
        output count, carry, seg, an
    );
endinterface

// File: rtl/bcd_digit.sv
// One BCD decade: a 4-bit cell that can be loaded and that counts up or down, modulo 10.
// The wrap output is set when the next step will roll this digit over.
// The top module chains the enables from one digit to the next through this output.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic       up_i,
    input  logic       load_i,
    input  logic [3:0] din_i,
    output logic [3:0] q_o,
    output logic       wrap_o
);

    logic [3:0] q_q;
    logic [3:0] q_d;

    // Next digit value; priority is load, then step, then hold. Non-decimal load data becomes 0.
    always_comb begin
        q_d = q_q;
        if (load_i) begin
            q_d = (din_i > 4'd9) ? 4'd0 : din_i;
        end else if (en_i) begin
            if (up_i) begin
                q_d = (q_q == 4'd9) ? 4'd0 : q_q + 4'd1;
            end else begin
                q_d = (q_q == 4'd0) ? 4'd9 : q_q - 4'd1;
            end
        end
    end

    // Digit register
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= 4'd0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o    = q_q;
    assign wrap_o = up_i ? (q_q == 4'd9) : (q_q == 4'd0);

endmodule

// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with a parallel load and a multiplexed 7-segment driver.
// A free-running prescaler steps the scan index, and the scan index selects one digit.
// The segment and anode outputs are registered, so they lag the count by one cycle.
module bcd_scan_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int SCAN_DIV    = 1000,
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter bit LZ_BLANK    = 1'b0
) (
    input  logic           clk,
    input  logic           rst_syn,
    bcd_scan_counter_if.slave bus
);

    localparam int PW    = $clog2(SCAN_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    function automatic logic [7:0] pol_seg(input logic [7:0] s);
        return SEG_ACT_LOW ? ~s : s;
    endfunction

    function automatic logic [DIGITS-1:0] pol_an(input logic [DIGITS-1:0] a);
        return SEG_ACT_LOW ? ~a : a;
    endfunction

    logic [3:0]        digit_q [DIGITS];
    logic [DIGITS-1:0] wrap;
    logic [DIGITS:0]   en_chain;
    logic [DIGITS-1:0] blank;

    logic [PW-1:0]     presc_q, presc_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              carry_q, carry_d;
    logic [7:0]        seg_q, seg_d;
    logic [DIGITS-1:0] an_q, an_d;

    logic [3:0]        nib_sel;
    logic              blank_sel;
    logic [7:0]        seg_raw;
    logic              zero_above;

    assign en_chain[0] = bus.en;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_digit
            bcd_digit u_digit (
                .clk    (clk),
                .rst    (rst_syn),
                .en_i   (en_chain[g]),
                .up_i   (bus.up),
                .load_i (bus.Load),
                .din_i  (bus.Din[4*g +: 4]),
                .q_o    (digit_q[g]),
                .wrap_o (wrap[g])
            );
            assign en_chain[g+1]    = en_chain[g] & wrap[g];
            assign bus.count[4*g +: 4] = digit_q[g];
        end
    endgenerate

    // The full counter wraps when every digit is at its rollover value while counting is enabled.
    // A load suppresses the wrap.
    assign carry_d = en_chain[DIGITS] & ~bus.Load;

    // Carry pulse register
    always_ff @(posedge clk) begin
        if (rst_syn) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= carry_d;
        end
    end

    // Prescaler and scan index advance; both run all the time, independent of en and Load
    always_comb begin
        presc_d = presc_q + PW'(1);
        idx_d   = idx_q;
        if (presc_q == PW'(SCAN_DIV - 1)) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Scan state registers
    always_ff @(posedge clk) begin
        if (rst_syn) begin
            presc_q <= '0;
            idx_q   <= '0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
        end
    end

    // Leading-zero mask: a digit above digit 0 is blanked when it and all higher digits are zero
    always_comb begin
        blank      = '0;
        zero_above = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_above = zero_above & (digit_q[k] == 4'd0);
            blank[k]   = LZ_BLANK & zero_above;
        end
    end

    // Select the digit that the scan index points to and decode it for the display
    always_comb begin
        nib_sel   = 4'd0;
        blank_sel = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                nib_sel   = digit_q[k];
                blank_sel = blank[k];
            end
        end
        seg_raw = blank_sel ? SEG_BLANK : bcd_to_seg(nib_sel);
        seg_d   = pol_seg(seg_raw);
        an_d    = pol_an(DIGITS'(1) << idx_q);
    end

    // Display output registers; after reset the display selects digit 0 and shows '0'
    always_ff @(posedge clk) begin
        if (rst_syn) begin
            seg_q <= pol_seg(SEG_0);
            an_q  <= pol_an(DIGITS'(1));
        end else begin
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign bus.carry = carry_q;
    assign bus.seg   = seg_q;
    assign bus.an    = an_q;

endmodule
